mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_rr_pick2.sv | 41 ++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way pick: the current owner keeps the port until its burst cap is hit
// while the other side waits; otherwise ties go to the side not served last.
module rr_pick2
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = 3
) (
  input  logic             valid0,
  input  logic             valid1,
  input  state_e           owner,
  input  logic [CNT_W-1:0] beat_cnt,
  input  logic             last,
  output logic             gnt0,
  output logic             gnt1
);

  logic under_cap;
  logic hold0;
  logic hold1;

  always_comb begin
    under_cap = beat_cnt < CNT_W'(MAX_BURST);
    hold0     = (owner == SERVE0) && valid0 && (under_cap || !valid1);
    hold1     = (owner == SERVE1) && valid1 && (under_cap || !valid0);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (hold0) begin
      gnt0 = 1'b1;
    end else if (hold1) begin
      gnt1 = 1'b1;
    end else if (valid0 && valid1) begin
      gnt0 = last;
      gnt1 = !last;
    end else begin
      gnt0 = valid0;
      gnt1 = valid1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous memory with
// burst capping and a fixed one-cycle read response pipeline.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_ren_n,
  output logic              mem_wen_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             last_q, last_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic              gnt0, gnt1, gnt_any, owner_hit;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  // Requests are masked during reset so no ready or memory strobe can escape.
  rr_pick2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .valid0   (req0_valid & rst_n),
    .valid1   (req1_valid & rst_n),
    .owner    (state_q),
    .beat_cnt (beat_q),
    .last     (last_q),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  always_comb begin
    gnt_any   = gnt0 | gnt1;
    g_we      = gnt1 ? req1_we    : req0_we;
    g_addr    = gnt1 ? req1_addr  : req0_addr;
    g_wdata   = gnt1 ? req1_wdata : req0_wdata;
    owner_hit = ((state_q == SERVE0) && gnt0) || ((state_q == SERVE1) && gnt1);

    mem_ren_n = 1'b1;
    mem_wen_n = 1'b1;
    mem_addr  = '0;
    mem_din   = '0;
    if (gnt_any) begin
      mem_addr = g_addr;
      if (g_we) begin
        mem_wen_n = 1'b0;
        mem_din   = g_wdata;
      end else begin
        mem_ren_n = 1'b0;
      end
    end

    state_d = IDLE;
    beat_d  = '0;
    last_d  = last_q;
    if (gnt_any) begin
      state_d = gnt1 ? SERVE1 : SERVE0;
      last_d  = gnt1;
      beat_d  = (owner_hit && (beat_q < CNT_W'(MAX_BURST))) ? beat_q + 1'b1 : CNT_W'(1);
    end

    rsp0_valid_d = gnt0 & ~req0_we;
    rsp1_valid_d = gnt1 & ~req1_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_valid_q ? mem_dout : '0;
  assign rsp1_rdata = rsp1_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of grants, memory contents and responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk, rst_n;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          mem_ren_n, mem_wen_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_ren_n(mem_ren_n), .mem_wen_n(mem_wen_n), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory device: read data one cycle after the read, 0 otherwise.
  logic [DW-1:0] mem [64];
  logic          init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem_dout <= '0;
    end else begin
      mem_dout <= !mem_ren_n ? mem[mem_addr] : '0;
      if (mem_ren_n && !mem_wen_n) mem[mem_addr] <= mem_din;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model state
  int            m_owner;     // -1 none, else requester currently holding the port
  int            m_beats;
  int            m_last;
  bit            m_pend [2];
  logic [DW-1:0] m_pdata [2];
  logic [DW-1:0] ref_mem [64];
  int            wait_cnt [2];
  int            max_wait;

  function automatic int exp_grant();
    bit v [2];
    v[0] = req0_valid;
    v[1] = req1_valid;
    if (m_owner >= 0 && v[m_owner] && (m_beats < MB || !v[1-m_owner])) return m_owner;
    if (v[0] && v[1]) return 1 - m_last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int            g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    g  = exp_grant();
    we = (g == 1) ? req1_we : req0_we;
    a  = (g == 1) ? req1_addr : req0_addr;
    d  = (g == 1) ? req1_wdata : req0_wdata;
    check_eq("ready0", req0_ready, g == 0);
    check_eq("ready1", req1_ready, g == 1);
    check_eq("ren_n", mem_ren_n, !(g >= 0 && !we));
    check_eq("wen_n", mem_wen_n, !(g >= 0 && we));
    check_eq("mem_addr", mem_addr, (g >= 0) ? a : '0);
    check_eq("mem_din", mem_din, (g >= 0 && we) ? d : '0);
    check_eq("rsp0_valid", rsp0_valid, m_pend[0]);
    check_eq("rsp0_rdata", rsp0_rdata, m_pend[0] ? m_pdata[0] : '0);
    check_eq("rsp1_valid", rsp1_valid, m_pend[1]);
    check_eq("rsp1_rdata", rsp1_rdata, m_pend[1] ? m_pdata[1] : '0);
    wait_cnt[0] = (req0_valid && g != 0) ? wait_cnt[0] + 1 : 0;
    wait_cnt[1] = (req1_valid && g != 1) ? wait_cnt[1] + 1 : 0;
    if (wait_cnt[0] > max_wait) max_wait = wait_cnt[0];
    if (wait_cnt[1] > max_wait) max_wait = wait_cnt[1];
    @(posedge clk);
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    if (g >= 0) begin
      if (!we) begin
        m_pend[g]  = 1'b1;
        m_pdata[g] = ref_mem[a];
      end else begin
        ref_mem[a] = d;
      end
      m_beats = (g == m_owner && m_beats < MB) ? m_beats + 1 : 1;
      m_owner = g;
      m_last  = g;
    end else begin
      m_owner = -1;
      m_beats = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);
    check_eq("rst_ren_n", mem_ren_n, 1'b1);
    check_eq("rst_wen_n", mem_wen_n, 1'b1);
    check_eq("rst_rsp0", {rsp0_valid, rsp0_rdata}, '0);
    check_eq("rst_rsp1", {rsp1_valid, rsp1_rdata}, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    m_owner     = -1;
    m_beats     = 0;
    m_last      = 1;
    m_pend[0]   = 1'b0;
    m_pend[1]   = 1'b0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  initial begin
    int n_rsp;
    idle_inputs();
    rst_n    = 1'b0;
    init_mem = 1'b1;
    max_wait = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    do_reset();

    // Idle: no strobes, no readies
    repeat (3) step();

    // Write then read-back on requester 0
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd5; req0_wdata = 8'hA5;
    step();
    req0_we = 1'b0; req0_wdata = '0;
    step();
    idle_inputs();
    check_eq("wr_rd_valid", rsp0_valid, 1'b1);
    check_eq("wr_rd_data", rsp0_rdata, 8'hA5);
    check_eq("wr_rd_rsp1", rsp1_valid, 1'b0);
    step();

    // Both requesters reading from reset release: bursts of MB alternate, req0 first
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4 * MB; i++) begin
      req0_addr = AW'(i % 8);
      req1_addr = AW'((i + 3) % 8);
      #1;
      check_eq("burst_pat", req0_ready, ((i / MB) % 2) == 0);
      check_eq("one_ready", req0_ready & req1_ready, 1'b0);
      step();
    end
    idle_inputs();
    step();

    // Requester 1 alone: preload, then 10 back-to-back reads
    req1_valid = 1'b1; req1_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req1_addr  = AW'(16 + i);
      req1_wdata = DW'(8'h30 + i);
      step();
    end
    req1_we = 1'b0; req1_wdata = '0;
    n_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      req1_addr = AW'(16 + i);
      step();
      if (rsp1_valid) n_rsp++;
    end
    idle_inputs();
    check_eq("last_data", rsp1_rdata, 8'h39);
    step();
    check_eq("rsp1_count", n_rsp, 10);

    // Reset pulsed right after an accepted read; requester still asserting valid
    req0_valid = 1'b1; req0_addr = 6'd5;
    step();
    do_reset();
    idle_inputs();
    check_eq("post_rst_rsp0", rsp0_valid, 1'b0);
    step();
    step();

    // Random mixed traffic over a small address window
    max_wait = 0;
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_we    = $urandom_range(0, 2) == 0;
      req0_addr  = AW'($urandom_range(0, 15));
      req0_wdata = DW'($urandom);
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_we    = $urandom_range(0, 2) == 0;
      req1_addr  = AW'($urandom_range(0, 15));
      req1_wdata = DW'($urandom);
      step();
    end
    idle_inputs();
    step();
    check_eq("no_starve", max_wait <= MB, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
